mc_main_control: RTL and testbench



---
 rtl/mips_pkg.sv | 64 ++++++
 rtl/mc_main_control_if.sv | 32 +++
 rtl/mc_state_decode.sv | 87 ++++++++
 rtl/mc_main_control.sv | 67 ++++++
 tb/tb_mc_main_control.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the multicycle MIPS control path:
// opcodes, ALU operation classes, mux selects, FSM states and the control vector.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Encodings 13..15 are unused and recover to S_IDLE.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       mem_read;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic [1:0] pc_src;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_main_control_if.sv
// Control-unit <-> datapath bundle: opcode/flags in, enables and mux selects out.
interface mc_main_control_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_en;
  logic       IorD;
  logic       MemWrite;
  logic       MemRead;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] Aluop;
  logic [1:0] PCSrc;
  logic       retire;
  logic       illegal;

  modport master (
    input  op, zero, mem_ready,
    output pc_en, IorD, MemWrite, MemRead, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, Aluop, PCSrc, retire, illegal
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_en, IorD, MemWrite, MemRead, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, Aluop, PCSrc, retire, illegal
  );
endinterface

// File: rtl/mc_state_decode.sv
// Combinational state -> control vector decode. Moore outputs, with the
// memory-state strobes qualified by mem_ready and the DECODE illegal check.
module mc_state_decode
  import mips_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  logic pc_write;
  logic branch;

  always_comb begin
    ctrl     = '0;
    pc_write = 1'b0;
    branch   = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        pc_write       = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.aluop     = ALUOP_ADD;
        // Unsupported opcodes retire straight out of DECODE.
        ctrl.illegal   = !op_legal(op);
        ctrl.retire    = !op_legal(op);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.retire    = mem_ready;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.aluop     = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.retire    = 1'b1;
        branch         = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.retire = 1'b1;
        pc_write    = 1'b1;
      end
      default: ;
    endcase
    ctrl.pc_en = pc_write | (branch & zero);
  end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control: state register and next-state sequencing;
// output decode lives in mc_state_decode.
module mc_main_control
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mc_main_control_if.master  bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  mc_state_decode u_decode (
    .state     (state_q),
    .op        (bus.op),
    .zero      (bus.zero),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  assign bus.pc_en    = ctrl.pc_en;
  assign bus.IorD     = ctrl.iord;
  assign bus.MemWrite = ctrl.mem_write;
  assign bus.MemRead  = ctrl.mem_read;
  assign bus.IRWrite  = ctrl.ir_write;
  assign bus.RegDst   = ctrl.reg_dst;
  assign bus.MemtoReg = ctrl.mem_to_reg;
  assign bus.RegWrite = ctrl.reg_write;
  assign bus.ALUSrcA  = ctrl.alu_src_a;
  assign bus.ALUSrcB  = ctrl.alu_src_b;
  assign bus.Aluop    = ctrl.aluop;
  assign bus.PCSrc    = ctrl.pc_src;
  assign bus.retire   = ctrl.retire;
  assign bus.illegal  = ctrl.illegal;

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: each instruction is expanded into its list of
// named steps and per-step expected outputs, then compared cycle by cycle.
module tb_mc_main_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  mc_main_control_if bus();

  mc_main_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {pc_en,IorD,MemWrite,MemRead,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,Aluop,PCSrc,retire,illegal}
  function automatic logic [16:0] observed();
    return {bus.pc_en, bus.IorD, bus.MemWrite, bus.MemRead, bus.IRWrite,
            bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
            bus.Aluop, bus.PCSrc, bus.retire, bus.illegal};
  endfunction

  function automatic logic [16:0] expect_step(input string step, input logic mr, input logic z);
    logic pce = 0, iord = 0, mw = 0, mrd = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, asa = 0;
    logic [1:0] asb = 2'b00, aop = 2'b00, psrc = 2'b00;
    logic ret = 0, ill = 0;
    case (step)
      "fetch":   begin mrd = 1; asb = 2'b01; irw = mr; pce = mr; end
      "decode":  asb = 2'b11;
      "illegal": begin asb = 2'b11; ill = 1; ret = 1; end
      "memadr":  begin asa = 1; asb = 2'b10; end
      "memrd":   begin mrd = 1; iord = 1; end
      "memwb":   begin rw = 1; m2r = 1; ret = 1; end
      "memwr":   begin mw = 1; iord = 1; ret = mr; end
      "execute": begin asa = 1; aop = 2'b10; end
      "aluwb":   begin rw = 1; rdst = 1; ret = 1; end
      "branch":  begin asa = 1; aop = 2'b01; psrc = 2'b01; pce = z; ret = 1; end
      "addiex":  begin asa = 1; asb = 2'b10; end
      "addiwb":  begin rw = 1; ret = 1; end
      "jump":    begin pce = 1; psrc = 2'b10; ret = 1; end
      default: ;
    endcase
    return {pce, iord, mw, mrd, irw, rdst, m2r, rw, asa, asb, aop, psrc, ret, ill};
  endfunction

  // Zero-wait latency from FETCH entry to retire.
  function automatic int base_latency(input logic [5:0] op);
    case (op)
      6'b000000: return 4;
      6'b100011: return 5;
      6'b101011: return 4;
      6'b001000: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      default:   return 2;
    endcase
  endfunction

  function automatic bit is_mem_op(input logic [5:0] op);
    return (op == 6'b100011) || (op == 6'b101011);
  endfunction

  // Runs one instruction starting in FETCH; stop_at >= 0 truncates after that many cycles.
  task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait,
                           input logic zero_v, input int stop_at, output int ret_cyc);
    string steps[$];
    logic  mrs[$];
    int    n;
    logic  z;
    logic [16:0] exp_v, got;
    for (int i = 0; i < fwait; i++) begin steps.push_back("fetch"); mrs.push_back(1'b0); end
    steps.push_back("fetch"); mrs.push_back(1'b1);
    case (op)
      6'b100011: begin
        steps.push_back("decode"); mrs.push_back(1'($urandom));
        steps.push_back("memadr"); mrs.push_back(1'($urandom));
        for (int i = 0; i < mwait; i++) begin steps.push_back("memrd"); mrs.push_back(1'b0); end
        steps.push_back("memrd"); mrs.push_back(1'b1);
        steps.push_back("memwb"); mrs.push_back(1'($urandom));
      end
      6'b101011: begin
        steps.push_back("decode"); mrs.push_back(1'($urandom));
        steps.push_back("memadr"); mrs.push_back(1'($urandom));
        for (int i = 0; i < mwait; i++) begin steps.push_back("memwr"); mrs.push_back(1'b0); end
        steps.push_back("memwr"); mrs.push_back(1'b1);
      end
      6'b000000: begin
        steps.push_back("decode");  mrs.push_back(1'($urandom));
        steps.push_back("execute"); mrs.push_back(1'($urandom));
        steps.push_back("aluwb");   mrs.push_back(1'($urandom));
      end
      6'b000100: begin
        steps.push_back("decode"); mrs.push_back(1'($urandom));
        steps.push_back("branch"); mrs.push_back(1'($urandom));
      end
      6'b001000: begin
        steps.push_back("decode"); mrs.push_back(1'($urandom));
        steps.push_back("addiex"); mrs.push_back(1'($urandom));
        steps.push_back("addiwb"); mrs.push_back(1'($urandom));
      end
      6'b000010: begin
        steps.push_back("decode"); mrs.push_back(1'($urandom));
        steps.push_back("jump");   mrs.push_back(1'($urandom));
      end
      default: begin
        steps.push_back("illegal"); mrs.push_back(1'($urandom));
      end
    endcase
    n = (stop_at >= 0 && stop_at < steps.size()) ? stop_at : steps.size();
    ret_cyc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      // The opcode only matters once the instruction register holds it.
      bus.op        = (steps[i] == "fetch") ? 6'($urandom) : op;
      bus.mem_ready = mrs[i];
      z             = (steps[i] == "branch") ? zero_v : 1'($urandom);
      bus.zero      = z;
      #1;
      exp_v = expect_step(steps[i], mrs[i], z);
      got   = observed();
      vectors++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL op=%b step=%s cyc=%0d outputs got=%b want=%b", op, steps[i], i + 1, got, exp_v);
      end
      if (got[1] === 1'b1 && ret_cyc == 0) ret_cyc = i + 1;
    end
  endtask

  task automatic check_latency(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL latency_%s retire_cycle got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_idle(input string name);
    #1;
    vectors++;
    if (observed() !== 17'd0) begin
      errors++;
      $display("FAIL %s outputs got=%b want=0", name, observed());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      bus.op = 6'($urandom); bus.mem_ready = 1'($urandom); bus.zero = 1'($urandom);
      check_idle("reset_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("reset_release_idle");
  endtask

  task automatic test_latencies();
    int rc;
    run_instr(6'b000000, 0, 0, 1'b0, -1, rc); check_latency("rtype", rc, 4);
    run_instr(6'b100011, 0, 3, 1'b0, -1, rc); check_latency("lw_wait3", rc, 8);
    run_instr(6'b101011, 0, 0, 1'b0, -1, rc); check_latency("sw", rc, 4);
    run_instr(6'b001000, 0, 0, 1'b0, -1, rc); check_latency("addi", rc, 4);
    run_instr(6'b000010, 0, 0, 1'b0, -1, rc); check_latency("j", rc, 3);
    run_instr(6'b000010, 2, 0, 1'b0, -1, rc); check_latency("j_fetchwait2", rc, 5);
  endtask

  task automatic test_branch();
    int rc;
    run_instr(6'b000100, 0, 0, 1'b1, -1, rc); check_latency("beq_taken", rc, 3);
    run_instr(6'b000100, 0, 0, 1'b0, -1, rc); check_latency("beq_not_taken", rc, 3);
  endtask

  task automatic test_illegal();
    int rc;
    run_instr(6'b111111, 0, 0, 1'b0, -1, rc); check_latency("illegal", rc, 2);
  endtask

  task automatic test_random();
    logic [5:0] legal [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] op;
    int fw, mw, rc, want;
    for (int k = 0; k < 60; k++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal[$urandom_range(0, 5)];
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      run_instr(op, fw, mw, 1'($urandom), -1, rc);
      want = base_latency(op) + fw + (is_mem_op(op) ? mw : 0);
      check_latency("random", rc, want);
    end
  endtask

  task automatic test_reset_mid();
    int rc;
    // fetch, decode, memadr, then two memwr wait cycles
    run_instr(6'b101011, 0, 5, 1'b0, 5, rc);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.MemWrite !== 1'b1 || bus.IorD !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre MemWrite/IorD got=%b%b want=11", bus.MemWrite, bus.IorD);
    end
    @(negedge clk);
    bus.mem_ready = 1'b1;
    check_idle("reset_mid_after_edge");
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("reset_mid_release");
    run_instr(6'b000000, 0, 0, 1'b0, -1, rc); check_latency("after_reset_rtype", rc, 4);
  endtask

  initial begin
    bus.op = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    test_reset();
    test_latencies();
    test_branch();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
